// File: rtl/tf_exp_gen.sv
// tf_exp_gen: twiddle-exponent sequencer for one radix-4 DIF FFT stage.
// Walks every butterfly b of stage s. For each issued butterfly it drives the
// four leg exponents EXPk = k * (b mod L) * 4^s, where L = 4^(LOG4N-1-s).
// It also emits valid/index sidebands, delayed to line up with the ROM's TF outputs.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   START, STAGE      one-cycle stage request and stage number (sampled in IDLE)
//   STALL             back-pressure; holds the butterfly walk while high
//   BUSY, ERR, DONE   status: stage active, bad-stage pulse, end-of-stage pulse
//   EXP0..EXP3        ROM read addresses for legs 0..3 (EXP0 is always 0)
//   EXP_VLD, BF_IDX   new butterfly on EXP0..3 and its index
//   TF_VLD, TF_IDX    EXP_VLD/BF_IDX delayed by ROM_LAT cycles
module tf_exp_gen #(
  parameter  int unsigned LOG4N   = 6,
  parameter  int unsigned ROM_LAT = 1,
  localparam int unsigned EW      = 2 * LOG4N,
  localparam int unsigned BW      = 2 * LOG4N - 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [2:0]    STAGE,
  input  logic          STALL,
  output logic          BUSY,
  output logic          ERR,
  output logic [EW-1:0] EXP0,
  output logic [EW-1:0] EXP1,
  output logic [EW-1:0] EXP2,
  output logic [EW-1:0] EXP3,
  output logic          EXP_VLD,
  output logic [BW-1:0] BF_IDX,
  output logic          TF_VLD,
  output logic [BW-1:0] TF_IDX,
  output logic          DONE
);

  localparam int unsigned NBF = 1 << BW;
  localparam int unsigned LW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

  state_t        r_state, w_next;
  logic [BW:0]   r_b, w_b_nxt, w_iss_b;   // r_b = next butterfly to issue
  logic [2:0]    r_s, w_s_nxt;
  logic [LW-1:0] r_fcnt, w_fcnt_nxt;
  logic          w_issue, w_err;

  logic [4:0]    w_jsh;
  logic [EW-1:0] w_mask, w_j, w_m, w_m2, w_m3;

  logic          r_busy, r_err, r_done, r_exp_vld;
  logic [EW-1:0] r_exp1, r_exp2, r_exp3;
  logic [BW-1:0] r_bf_idx;
  logic          r_vld_dl [ROM_LAT];
  logic [BW-1:0] r_idx_dl [ROM_LAT];

  // Next-state and issue decision
  always_comb begin
    w_next     = r_state;
    w_b_nxt    = r_b;
    w_s_nxt    = r_s;
    w_fcnt_nxt = r_fcnt;
    w_iss_b    = r_b;
    w_issue    = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          if (32'(STAGE) < LOG4N) begin
            // Butterfly 0 goes out on the accepting edge
            w_next  = S_RUN;
            w_s_nxt = STAGE;
            w_iss_b = '0;
            w_issue = 1'b1;
            w_b_nxt = (BW+1)'(1);
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_b == (BW+1)'(NBF)) begin
          // Last butterfly is on the outputs now; drain the ROM pipeline
          w_next     = S_FLUSH;
          w_fcnt_nxt = '0;
        end else if (!STALL) begin
          w_issue = 1'b1;
          w_b_nxt = r_b + (BW+1)'(1);
        end
      end
      S_FLUSH: begin
        if (r_fcnt == LW'(ROM_LAT - 1)) w_next = S_FIN;
        else                            w_fcnt_nxt = r_fcnt + LW'(1);
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Exponent arithmetic: j = low 2*(LOG4N-1-s) bits of b, m = j << 2s
  always_comb begin
    w_jsh  = 5'(2 * (LOG4N - 1)) - 5'({w_s_nxt, 1'b0});
    w_mask = EW'((EW'(1) << w_jsh) - EW'(1));
    w_j    = EW'(w_iss_b[BW-1:0]) & w_mask;
    w_m    = EW'(w_j << {w_s_nxt, 1'b0});
    w_m2   = {w_m[EW-2:0], 1'b0};
    w_m3   = w_m + w_m2;
  end

  // State, control and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_b       <= '0;
      r_s       <= '0;
      r_fcnt    <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_exp_vld <= 1'b0;
      r_exp1    <= '0;
      r_exp2    <= '0;
      r_exp3    <= '0;
      r_bf_idx  <= '0;
    end else begin
      r_state   <= w_next;
      r_b       <= w_b_nxt;
      r_s       <= w_s_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_busy    <= (w_next != S_IDLE);
      r_err     <= w_err;
      r_done    <= (w_next == S_FIN);
      r_exp_vld <= w_issue;
      // Exponents hold while stalled so the ROM output stays stable
      if (w_issue) begin
        r_exp1   <= w_m;
        r_exp2   <= w_m2;
        r_exp3   <= w_m3;
        r_bf_idx <= w_iss_b[BW-1:0];
      end
    end
  end

  // TF sideband delay line; free-running, never gated by STALL
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_vld_dl[i] <= 1'b0;
        r_idx_dl[i] <= '0;
      end
    end else begin
      r_vld_dl[0] <= r_exp_vld;
      r_idx_dl[0] <= r_bf_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld_dl[i] <= r_vld_dl[i-1];
        r_idx_dl[i] <= r_idx_dl[i-1];
      end
    end
  end

  assign BUSY    = r_busy;
  assign ERR     = r_err;
  assign DONE    = r_done;
  assign EXP0    = '0;
  assign EXP1    = r_exp1;
  assign EXP2    = r_exp2;
  assign EXP3    = r_exp3;
  assign EXP_VLD = r_exp_vld;
  assign BF_IDX  = r_bf_idx;
  assign TF_VLD  = r_vld_dl[ROM_LAT-1];
  assign TF_IDX  = r_idx_dl[ROM_LAT-1];

endmodule

// File: tb/tb_tf_exp_gen.sv
// tb_tf_exp_gen: bench for tf_exp_gen with an attached stand-in twiddle ROM
// (1-cycle registered lookup) and an arithmetic model of the exponent rule.
`timescale 1ns/1ps
module tb_tf_exp_gen;

  localparam int LOG4N = 6;
  localparam int NBF   = 1024;

  logic        CLK = 1'b0;
  logic        RST, START, STALL;
  logic [2:0]  STAGE;
  logic        BUSY, ERR, EXP_VLD, TF_VLD, DONE;
  logic [11:0] EXP0, EXP1, EXP2, EXP3;
  logic [9:0]  BF_IDX, TF_IDX;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  tf_exp_gen #(.LOG4N(6), .ROM_LAT(1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STAGE(STAGE), .STALL(STALL),
    .BUSY(BUSY), .ERR(ERR),
    .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3),
    .EXP_VLD(EXP_VLD), .BF_IDX(BF_IDX),
    .TF_VLD(TF_VLD), .TF_IDX(TF_IDX), .DONE(DONE)
  );

  // Stand-in ROM contents: arbitrary but address-unique pattern
  function automatic logic [15:0] rom_word(input logic [11:0] a);
    return 16'((int'(a) * 40503) ^ 23130);
  endfunction

  logic [15:0] tf [4];
  always @(posedge CLK) begin
    tf[0] <= rom_word(EXP0);
    tf[1] <= rom_word(EXP1);
    tf[2] <= rom_word(EXP2);
    tf[3] <= rom_word(EXP3);
  end

  // Reference exponent: k * (b mod L) * 4^s with L = 4^(LOG4N-1-s)
  function automatic int exp_ref(input int k, input int b, input int s);
    int span, step;
    span = 4 ** (LOG4N - 1 - s);
    step = 4 ** s;
    return k * (b % span) * step;
  endfunction

  // Observations of the last run
  int          q_idx [$];
  bit          h_vld [$];
  bit          h_tfv [$];
  int          h_bi  [$];
  int          h_ti  [$];
  logic [11:0] o_exp [4][NBF];
  logic [15:0] o_tf  [4][NBF];
  int done_cyc, eff_stalls, n_vld, n_chg, n_err;
  bit timed_out, busy_first, vld_first, busy_after, done_after;

  function automatic int count_exp_bad(input int s);
    int bad = 0;
    for (int b = 0; b < NBF; b++)
      for (int k = 0; k < 4; k++)
        if (int'(o_exp[k][b]) != exp_ref(k, b, s)) bad++;
    return bad;
  endfunction

  function automatic int count_tf_bad(input int s);
    int bad = 0;
    for (int b = 0; b < NBF; b++)
      for (int k = 0; k < 4; k++)
        if (o_tf[k][b] !== rom_word(12'(exp_ref(k, b, s)))) bad++;
    return bad;
  endfunction

  function automatic int count_seq_bad();
    int bad = 0;
    if (q_idx.size() != NBF) bad++;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != i) bad++;
    return bad;
  endfunction

  // TF_VLD/TF_IDX must equal EXP_VLD/BF_IDX of the previous cycle
  function automatic int count_lag_bad();
    int bad = 0;
    if (h_tfv.size() > 0 && h_tfv[0]) bad++;
    for (int i = 1; i < h_tfv.size(); i++) begin
      if (h_tfv[i] != h_vld[i-1]) bad++;
      else if (h_tfv[i] && h_ti[i] != h_bi[i-1]) bad++;
    end
    return bad;
  endfunction

  // Runs one stage, recording what the DUT produced; cycle 1 follows the START edge
  task automatic run_stage(input int s, input int stall_pct, input int poke_period,
                           input bit start_at_done);
    logic [47:0] prev;
    q_idx.delete(); h_vld.delete(); h_tfv.delete(); h_bi.delete(); h_ti.delete();
    for (int b = 0; b < NBF; b++)
      for (int k = 0; k < 4; k++) begin
        o_exp[k][b] = '1;
        o_tf[k][b]  = '1;
      end
    done_cyc = 0; eff_stalls = 0; n_vld = 0; n_chg = 0; n_err = 0;
    timed_out = 1'b1; busy_after = 1'b1; done_after = 1'b1;
    prev = '0;
    START = 1'b1; STAGE = 3'(s); STALL = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    busy_first = BUSY;
    vld_first  = EXP_VLD;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      h_vld.push_back(EXP_VLD); h_tfv.push_back(TF_VLD);
      h_bi.push_back(int'(BF_IDX)); h_ti.push_back(int'(TF_IDX));
      if (EXP_VLD) begin
        q_idx.push_back(int'(BF_IDX));
        n_vld++;
        o_exp[0][BF_IDX] = EXP0; o_exp[1][BF_IDX] = EXP1;
        o_exp[2][BF_IDX] = EXP2; o_exp[3][BF_IDX] = EXP3;
      end else if (cyc > 1 && {EXP0, EXP1, EXP2, EXP3} != prev) begin
        n_chg++;
      end
      prev = {EXP0, EXP1, EXP2, EXP3};
      if (TF_VLD)
        for (int k = 0; k < 4; k++) o_tf[k][TF_IDX] = tf[k];
      if (ERR) n_err++;
      if (DONE) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        START = start_at_done; STAGE = 3'd1; STALL = 1'b0;
        @(posedge CLK); #1;
        busy_after = BUSY;
        done_after = DONE;
        START = 1'b0;
        break;
      end
      // Stall only counts while butterflies are still pending
      STALL = (n_vld < NBF) && ($urandom_range(99) < stall_pct);
      if (STALL) eff_stalls++;
      if (poke_period > 0 && (cyc % poke_period) == 0) begin
        START = 1'b1;
        STAGE = 3'($urandom_range(7));
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
    end
    STALL = 1'b0;
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; STALL = 1'b0; STAGE = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({BUSY, ERR, EXP_VLD, TF_VLD, DONE} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {BUSY, ERR, EXP_VLD, TF_VLD, DONE});
    end
    n_tests++;
    if ({EXP0, EXP1, EXP2, EXP3} !== 48'h0) begin
      n_fail++; $display("FAIL reset_exp got %h want 0", {EXP0, EXP1, EXP2, EXP3});
    end
    n_tests++;
    if ({BF_IDX, TF_IDX} !== 20'h0) begin
      n_fail++; $display("FAIL reset_idx got %h want 0", {BF_IDX, TF_IDX});
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_stage0();
    run_stage(0, 0, 0, 1'b0);
    n_tests++;
    if (timed_out || done_cyc != 1026) begin
      n_fail++; $display("FAIL s0_done_cycle got %0d (timeout=%0b) want 1026", done_cyc, timed_out);
    end
    n_tests++;
    if (n_vld != NBF) begin
      n_fail++; $display("FAIL s0_vld_count got %0d want %0d", n_vld, NBF);
    end
    n_tests++;
    if (!(busy_first && vld_first) || q_idx.size() == 0 || q_idx[0] != 0) begin
      n_fail++; $display("FAIL s0_first_issue busy=%0b vld=%0b want 1 1 at b=0", busy_first, vld_first);
    end
    n_tests++;
    if ({o_exp[0][5], o_exp[1][5], o_exp[2][5], o_exp[3][5]} !== {12'd0, 12'd5, 12'd10, 12'd15}) begin
      n_fail++; $display("FAIL s0_b5 got %0d %0d %0d %0d want 0 5 10 15",
                         o_exp[0][5], o_exp[1][5], o_exp[2][5], o_exp[3][5]);
    end
    n_tests++;
    if (count_exp_bad(0) != 0) begin
      n_fail++; $display("FAIL s0_all_exp got %0d bad want 0", count_exp_bad(0));
    end
    n_tests++;
    if (busy_after !== 1'b0 || done_after !== 1'b0) begin
      n_fail++; $display("FAIL s0_after_done busy=%0b done=%0b want 0 0", busy_after, done_after);
    end
  endtask

  task automatic test_stage_values();
    run_stage(1, 0, 0, 1'b0);
    n_tests++;
    if ({o_exp[0][300], o_exp[1][300], o_exp[2][300], o_exp[3][300]} !== {12'd0, 12'd176, 12'd352, 12'd528}) begin
      n_fail++; $display("FAIL s1_b300 got %0d %0d %0d %0d want 0 176 352 528",
                         o_exp[0][300], o_exp[1][300], o_exp[2][300], o_exp[3][300]);
    end
    n_tests++;
    if (count_exp_bad(1) != 0 || done_cyc != 1026) begin
      n_fail++; $display("FAIL s1_all_exp got %0d bad done=%0d want 0 1026", count_exp_bad(1), done_cyc);
    end
    run_stage(2, 0, 0, 1'b0);
    n_tests++;
    if ({o_exp[0][63], o_exp[1][63], o_exp[2][63], o_exp[3][63]} !== {12'd0, 12'd1008, 12'd2016, 12'd3024}) begin
      n_fail++; $display("FAIL s2_b63 got %0d %0d %0d %0d want 0 1008 2016 3024",
                         o_exp[0][63], o_exp[1][63], o_exp[2][63], o_exp[3][63]);
    end
    n_tests++;
    if (count_exp_bad(2) != 0) begin
      n_fail++; $display("FAIL s2_all_exp got %0d bad want 0", count_exp_bad(2));
    end
    run_stage(5, 0, 0, 1'b0);
    n_tests++;
    if (count_exp_bad(5) != 0 || n_vld != NBF) begin
      n_fail++; $display("FAIL s5_all_zero got %0d bad n_vld=%0d want 0 %0d", count_exp_bad(5), n_vld, NBF);
    end
  endtask

  task automatic test_bad_stage();
    for (int s = 6; s < 8; s++) begin
      int hi = 0;
      START = 1'b1; STAGE = 3'(s);
      @(posedge CLK); #1;
      START = 1'b0;
      n_tests++;
      if (ERR !== 1'b1 || BUSY !== 1'b0) begin
        n_fail++; $display("FAIL bad_stage%0d_err err=%0b busy=%0b want 1 0", s, ERR, BUSY);
      end
      @(posedge CLK); #1;
      n_tests++;
      if (ERR !== 1'b0) begin
        n_fail++; $display("FAIL bad_stage%0d_pulse err=%0b want 0", s, ERR);
      end
      for (int c = 0; c < 4; c++) begin
        if (BUSY || EXP_VLD || TF_VLD || DONE) hi++;
        @(posedge CLK); #1;
      end
      n_tests++;
      if (hi != 0) begin
        n_fail++; $display("FAIL bad_stage%0d_quiet got %0d active cycles want 0", s, hi);
      end
    end
  endtask

  task automatic test_stall(input int pct);
    int s;
    s = int'($urandom_range(5));
    run_stage(s, pct, 0, 1'b0);
    n_tests++;
    if (count_seq_bad() != 0) begin
      n_fail++; $display("FAIL stall%0d_seq got %0d bad (n=%0d) want 0", pct, count_seq_bad(), q_idx.size());
    end
    n_tests++;
    if (count_lag_bad() != 0) begin
      n_fail++; $display("FAIL stall%0d_tf_lag got %0d bad want 0", pct, count_lag_bad());
    end
    n_tests++;
    if (count_tf_bad(s) != 0 || count_exp_bad(s) != 0) begin
      n_fail++; $display("FAIL stall%0d_tf_data s=%0d got %0d/%0d bad want 0", pct, s,
                         count_tf_bad(s), count_exp_bad(s));
    end
    n_tests++;
    if (timed_out || done_cyc != 1026 + eff_stalls) begin
      n_fail++; $display("FAIL stall%0d_length got %0d want %0d", pct, done_cyc, 1026 + eff_stalls);
    end
    n_tests++;
    if (n_chg != 0) begin
      n_fail++; $display("FAIL stall%0d_exp_hold got %0d changes want 0", pct, n_chg);
    end
  endtask

  task automatic test_start_busy();
    run_stage(1, 20, 97, 1'b0);
    n_tests++;
    if (count_exp_bad(1) != 0 || count_seq_bad() != 0) begin
      n_fail++; $display("FAIL busy_start_exp got %0d/%0d bad want 0", count_exp_bad(1), count_seq_bad());
    end
    n_tests++;
    if (n_err != 0 || done_cyc != 1026 + eff_stalls) begin
      n_fail++; $display("FAIL busy_start_ctrl err=%0d done=%0d want 0 %0d", n_err, done_cyc, 1026 + eff_stalls);
    end
  endtask

  task automatic test_back_to_back();
    run_stage(0, 0, 0, 1'b1);
    n_tests++;
    if (busy_after !== 1'b0 || done_after !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_in_done busy=%0b done=%0b want 0 0", busy_after, done_after);
    end
    run_stage(1, 0, 0, 1'b0);
    n_tests++;
    if (!busy_first || !vld_first || done_cyc != 1026 || count_exp_bad(1) != 0) begin
      n_fail++; $display("FAIL b2b_second busy=%0b vld=%0b done=%0d bad=%0d want 1 1 1026 0",
                         busy_first, vld_first, done_cyc, count_exp_bad(1));
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int seen_done = 0;
    START = 1'b1; STAGE = 3'd0; STALL = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (DONE) seen_done++;
      if (EXP_VLD && BF_IDX == 10'd500) begin
        found = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL rst_mid_reach got no b=500 want b=500 issued");
    end
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({BUSY, ERR, EXP_VLD, TF_VLD, DONE} !== 5'b0 || {EXP0, EXP1, EXP2, EXP3, BF_IDX, TF_IDX} !== 68'h0) begin
      n_fail++; $display("FAIL rst_mid_async flags=%b data=%h want 0 0", {BUSY, ERR, EXP_VLD, TF_VLD, DONE},
                         {EXP0, EXP1, EXP2, EXP3, BF_IDX, TF_IDX});
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (DONE || BUSY) seen_done++;
      @(posedge CLK); #1;
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", seen_done);
    end
    run_stage(2, 10, 0, 1'b0);
    n_tests++;
    if (count_seq_bad() != 0 || count_exp_bad(2) != 0 || done_cyc != 1026 + eff_stalls) begin
      n_fail++; $display("FAIL rst_mid_rerun seq=%0d exp=%0d done=%0d want 0 0 %0d",
                         count_seq_bad(), count_exp_bad(2), done_cyc, 1026 + eff_stalls);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STALL = 1'b0; STAGE = '0;
    test_reset();
    test_stage0();
    test_stage_values();
    test_bad_stage();
    test_stall(30);
    test_stall(60);
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
